mont_precompute: RTL
====================

# mont_precompute

Operand precompute stage for the radix-4 Montgomery multiplier. It captures modulus M and operand B, then produces the six multiples M, 2M, 3M, B, 2B and 3B as 1027-bit registered values. These values feed the six data inputs of the registered operand-select multiplexer that drives the accumulator adder. 3B and 3M are formed by a chunked, carry-registered addition so that no full-width 1027-bit carry chain exists in one cycle.

## Interface
- CHUNK_W, default 128: width of the adder slice used per cycle. Legal range is 32 to 1027.
- NCHUNK, default ceil(1026/CHUNK_W) = 9: number of addition cycles. It is derived, not user-set.
- clk  in  1  clock.
- resetn  in  1  reset: synchronous, active-low.
- start  in  1  request. Sampled only in IDLE; ignored otherwise.
- in_M  in  1024  modulus. Sampled on the accepting edge.
- in_B  in  1024  operand. Sampled on the accepting edge.
- busy  out  1  high in ADD and DONE.
- done  out  1  one-cycle pulse when all six outputs are final.
- valid  out  1  level. High from done until the next accepted start or reset.
- out_M, out_2M, out_3M, out_B, out_2B, out_3B  out  1027 each  zero-extended multiples, registered.

## Operation
- States:
  - IDLE: start=1 moves to ADD.
  - ADD: stays for NCHUNK cycles, then moves to DONE.
  - DONE: always moves to IDLE.
- Accepting edge (IDLE & start):
  - out_M ← zext(in_M); out_B ← zext(in_B).
  - out_2M ← zext(in_M)<<1; out_2B ← zext(in_B)<<1.
  - out_3M, out_3B ← 0.
  - Chunk counter ← 0; both carries ← 0; valid ← 0.
- ADD, counter k:
  - Slice k (bits k·CHUNK_W .. k·CHUNK_W+CHUNK_W−1) of out_3B ← slice_k(out_B) + slice_k(out_2B) + carry_B.
  - carry_B ← carry-out of that addition.
  - out_3M is computed identically from out_M, out_2M and carry_M.
  - k increments each cycle.
- Width rules:
  - Operands are zero-padded internally to NCHUNK·CHUNK_W bits.
  - Results are truncated to 1027 bits.
  - 3·(2^1024−1) < 2^1026, so bit 1026 of each output is always 0 and the final carry is always 0. The final carry is not an error.
- DONE: done=1 and valid←1 for exactly this cycle.
- The block has no exits from ADD other than reset. A start received while busy is dropped, not queued.
- Back-to-back operation: start high in the cycle after done is accepted, because the block is in IDLE then.
- Reset (resetn=0 at an edge):
  - state←IDLE; done, busy, valid←0.
  - All six outputs ←0; counter and carries ←0.
  - Mid-operation reset aborts with no partial results retained.

## Timing
- Edge 0 = the edge that samples start in IDLE.
- out_M, out_2M, out_B and out_2B are valid after edge 0.
- Slice k of out_3B and out_3M is written at edge k+1, for k = 0 .. NCHUNK−1.
- done is high in the cycle after edge NCHUNK+1 and is low again after edge NCHUNK+2. With defaults, done is asserted 10 edges after the start edge.
- busy is high from edge 1 through edge NCHUNK+1.
- Outputs hold their values while in IDLE, so the downstream mux may read them any time valid=1.
- Critical path is one CHUNK_W-bit add plus carry. There is no combinational path from inputs to outputs.

## Structure
- Shared package (mont_pkg):
  - OPW = 1024 and XW = 1027 width constants.
  - State enum {IDLE, ADD, DONE}.
  - NCHUNK derivation function.
- Sub-module mont_chunk_add: CHUNK_W-bit adder with carry-in and carry-out, combinational. It is instantiated twice, once for the B path and once for the M path.
- The top level holds the FSM, counter, carry flops and output registers.

## Test plan
- B=1, M=1, start → done 10 edges after start edge; out_3B=3, out_3M=3, out_2B=2, valid=1.
- B=2^1024−1, M=2^1023+1 → out_3B=3·2^1024−3, out_3M=3·2^1023+3. This checks carry propagation across all 9 slices; bit 1026 is 0.
- B=2^128−1, M=0 → out_3B=3·2^128−3, exercising the slice-0 to slice-1 carry; out_3M=0.
- start held high through busy → exactly one done per 11 cycles; a start present in the done cycle is accepted in the next IDLE cycle. Outputs stay unchanged while busy except for 3B/3M slices.
- resetn=0 at edge 4 of an operation → next cycle busy=0, valid=0, all outputs 0. A fresh start then completes normally with correct results.
- CHUNK_W=1027 (NCHUNK=1) with B=5 → out_3B=15, done 2 edges after start edge.

Source files
------------

// File: rtl/mont_pkg.sv
// Shared widths, state encoding and chunk-count helper for the Montgomery
// operand precompute stage.
package mont_pkg;

   // Operand width and the extended width that holds 3x an operand
   localparam int OPW = 1024;
   localparam int XW  = 1027;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of adder slices needed to cover the 1026 significant result bits
   function automatic int calc_nchunk(input int chunkW);
      return (XW - 1 + chunkW - 1) / chunkW;
   endfunction

endpackage

// File: rtl/mont_chunk_add.sv
// One adder slice with carry-in and carry-out, purely combinational.
module mont_chunk_add #(
   parameter int W = 128
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_sum,
   output logic         o_cout
);

   // Widen by one bit so the carry-out falls out of the top of the sum
   assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

endmodule

// File: rtl/mont_precompute.sv
// Captures M and B, then builds M, 2M, 3M, B, 2B, 3B as registered 1027-bit
// values. 3M and 3B are formed one slice per cycle with a registered carry so
// no full-width carry chain exists within a single cycle.
module mont_precompute
   import mont_pkg::*;
#(
   parameter int CHUNK_W = 128
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   input  logic [OPW-1:0] in_M,
   input  logic [OPW-1:0] in_B,
   output logic          busy,
   output logic          done,
   output logic          valid,
   output logic [XW-1:0] out_M,
   output logic [XW-1:0] out_2M,
   output logic [XW-1:0] out_3M,
   output logic [XW-1:0] out_B,
   output logic [XW-1:0] out_2B,
   output logic [XW-1:0] out_3B
);

   localparam int NCHUNK = calc_nchunk(CHUNK_W);
   localparam int CNT_W  = $clog2(NCHUNK + 1);

   state_t             r_state;
   state_t             w_nextState;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_carryB;
   logic               r_carryM;
   logic               r_busy;
   logic               r_done;
   logic               r_valid;
   logic [XW-1:0]      r_M;
   logic [XW-1:0]      r_2M;
   logic [XW-1:0]      r_3M;
   logic [XW-1:0]      r_B;
   logic [XW-1:0]      r_2B;
   logic [XW-1:0]      r_3B;
   logic [CHUNK_W-1:0] w_sliceB;
   logic [CHUNK_W-1:0] w_slice2B;
   logic [CHUNK_W-1:0] w_sliceM;
   logic [CHUNK_W-1:0] w_slice2M;
   logic [CHUNK_W-1:0] w_sumB;
   logic [CHUNK_W-1:0] w_sumM;
   logic               w_coutB;
   logic               w_coutM;
   logic               w_lastChunk;

   assign w_lastChunk = (r_cnt == CNT_W'(NCHUNK - 1));

   // Pick slice r_cnt of each operand; bits past the 1027-bit value read as 0
   always_comb begin
      int idx;
      idx       = 0;
      w_sliceB  = '0;
      w_slice2B = '0;
      w_sliceM  = '0;
      w_slice2M = '0;
      for (int j = 0; j < CHUNK_W; j++) begin
         idx = int'(r_cnt) * CHUNK_W + j;
         if (idx < XW) begin
            w_sliceB[j]  = r_B[idx];
            w_slice2B[j] = r_2B[idx];
            w_sliceM[j]  = r_M[idx];
            w_slice2M[j] = r_2M[idx];
         end
      end
   end

   mont_chunk_add #(.W(CHUNK_W)) u_addB (
      .i_a    (w_sliceB),
      .i_b    (w_slice2B),
      .i_cin  (r_carryB),
      .o_sum  (w_sumB),
      .o_cout (w_coutB)
   );

   mont_chunk_add #(.W(CHUNK_W)) u_addM (
      .i_a    (w_sliceM),
      .i_b    (w_slice2M),
      .i_cin  (r_carryM),
      .o_sum  (w_sumM),
      .o_cout (w_coutM)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_nextState;
   end

   // Next-state logic: IDLE waits for start, ADD runs NCHUNK slices, DONE is one cycle
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (start) w_nextState = ADD;
         ADD:     if (w_lastChunk) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Datapath: load on accept, write one 3x slice per ADD cycle, flag lag the state by one edge
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_cnt    <= '0;
         r_carryB <= 1'b0;
         r_carryM <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_valid  <= 1'b0;
         r_M      <= '0;
         r_2M     <= '0;
         r_3M     <= '0;
         r_B      <= '0;
         r_2B     <= '0;
         r_3B     <= '0;
      end else begin
         r_busy <= (r_state != IDLE);
         r_done <= (r_state == DONE);
         if (r_state == DONE) r_valid <= 1'b1;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_M      <= XW'(in_M);
                  r_2M     <= {2'b00, in_M, 1'b0};
                  r_B      <= XW'(in_B);
                  r_2B     <= {2'b00, in_B, 1'b0};
                  r_3M     <= '0;
                  r_3B     <= '0;
                  r_cnt    <= '0;
                  r_carryB <= 1'b0;
                  r_carryM <= 1'b0;
                  r_valid  <= 1'b0;
               end
            end
            ADD: begin
               for (int i = 0; i < XW; i++) begin
                  if ((i / CHUNK_W) == int'(r_cnt)) begin
                     r_3B[i] <= w_sumB[i % CHUNK_W];
                     r_3M[i] <= w_sumM[i % CHUNK_W];
                  end
               end
               r_carryB <= w_coutB;
               r_carryM <= w_coutM;
               r_cnt    <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign valid  = r_valid;
   assign out_M  = r_M;
   assign out_2M = r_2M;
   assign out_3M = r_3M;
   assign out_B  = r_B;
   assign out_2B = r_2B;
   assign out_3B = r_3B;

endmodule
